axis_rr_mux: RTL and testbench

N-channel AXI-stream multiplexer with round-robin arbitration. It merges N_CHANNELS axi_stream slave inputs onto one registered axi_stream master output. It is the parametrised successor of the single-channel axi_stream path, generalised in channel count, with beat-level or packet-level (tlast-locked) arbitration and optional source tagging on dest. It sits between multiple data producers (ADC front-ends, scope channels) and shared consumers such as a DMA or a packet assembler.

---
 rtl/axis_rr_mux_if.sv | 17 +
 rtl/axis_rr_mux.sv | 178 +++++++++++++++++
 tb/tb_axis_rr_mux.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rr_mux_if.sv
// AXI-stream bundle used on both sides of axis_rr_mux.
// master drives the beat, slave drives ready.
interface axi_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 32,
    parameter int DEST_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [USER_WIDTH-1:0] user;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tlast;

    modport master (output valid, data, user, dest, tlast, input ready);
    modport slave  (input valid, data, user, dest, tlast, output ready);
endinterface

// File: rtl/axis_rr_mux.sv
// N-channel AXI-stream round-robin mux with a registered output stage.
// Define AXIS_MUX_LOCK_TIMEOUT_EN to release stalled packet locks after TIMEOUT_CYCLES.

module axis_rr_mux_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 32,
    parameter int DEST_WIDTH = 32
) (
    axi_stream.slave              s,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [USER_WIDTH-1:0] user,
    output logic [DEST_WIDTH-1:0] dest,
    output logic                  tlast
);
    assign valid   = s.valid;
    assign data    = s.data;
    assign user    = s.user;
    assign dest    = s.dest;
    assign tlast   = s.tlast;
    assign s.ready = ready;
endmodule

module axis_rr_mux #(
    parameter int N_CHANNELS     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int USER_WIDTH     = 32,
    parameter int DEST_WIDTH     = 32,
    parameter int PACKET_MODE    = 0,
    parameter int TAG_DEST       = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic      clock,
    input  logic      reset,
    axi_stream.slave  stream_in [N_CHANNELS],
    axi_stream.master stream_out
`ifdef AXIS_MUX_LOCK_TIMEOUT_EN
    ,
    output logic      lock_timeout
`endif
);
    localparam int IDX_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [USER_WIDTH-1:0] user;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tlast;
    } beat_t;

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    logic [N_CHANNELS-1:0]                 in_valid;
    logic [N_CHANNELS-1:0]                 in_ready;
    logic [N_CHANNELS-1:0]                 in_last;
    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] in_data;
    logic [N_CHANNELS-1:0][USER_WIDTH-1:0] in_user;
    logic [N_CHANNELS-1:0][DEST_WIDTH-1:0] in_dest;

    state_t state_q, state_d;
    idx_t   ptr_q, grant;
    logic   grant_valid, out_free, accept, to_fire;
    logic   out_valid_q;
    beat_t  out_q, sel_beat;

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_lane
        axis_rr_mux_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .USER_WIDTH(USER_WIDTH),
            .DEST_WIDTH(DEST_WIDTH)
        ) u_lane (
            .s     (stream_in[g]),
            .ready (in_ready[g]),
            .valid (in_valid[g]),
            .data  (in_data[g]),
            .user  (in_user[g]),
            .dest  (in_dest[g]),
            .tlast (in_last[g])
        );
        assign in_ready[g] = accept && (grant == idx_t'(g));
    end

    // Descending scan: the channel nearest after the pointer is written last and wins.
    always_comb begin
        int c;
        c           = 0;
        grant       = ptr_q;
        grant_valid = 1'b0;
        if (state_q == ST_LOCKED) begin
            grant_valid = in_valid[ptr_q];
        end else begin
            for (int k = N_CHANNELS; k >= 1; k--) begin
                c = int'(ptr_q) + k;
                if (c >= N_CHANNELS) c = c - N_CHANNELS;
                if (in_valid[idx_t'(c)]) begin
                    grant       = idx_t'(c);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign out_free = !out_valid_q || stream_out.ready;
    assign accept   = grant_valid && out_free && !reset;

    always_comb begin
        sel_beat       = '0;
        sel_beat.data  = in_data[grant];
        sel_beat.user  = in_user[grant];
        sel_beat.tlast = in_last[grant];
        sel_beat.dest  = (TAG_DEST != 0) ? DEST_WIDTH'(grant) : in_dest[grant];
    end

    // Lock follows the last accepted beat; the locked channel is always ptr_q.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ((PACKET_MODE != 0) && !sel_beat.tlast) ? ST_LOCKED : ST_OPEN;
        end else if (to_fire) begin
            state_d = ST_OPEN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_OPEN;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q       <= idx_t'(N_CHANNELS - 1);
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (accept) begin
            ptr_q       <= grant;
            out_valid_q <= 1'b1;
            out_q       <= sel_beat;
        end else if (stream_out.ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign stream_out.valid = out_valid_q;
    assign stream_out.data  = out_q.data;
    assign stream_out.user  = out_q.user;
    assign stream_out.dest  = out_q.dest;
    assign stream_out.tlast = out_q.tlast;

`ifdef AXIS_MUX_LOCK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] to_cnt_q;
    logic             stall, to_pulse_q;

    // Counts only cycles where the locked owner has nothing to offer.
    assign stall   = (state_q == ST_LOCKED) && !in_valid[ptr_q];
    assign to_fire = stall && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q   <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            to_pulse_q <= to_fire;
            if (accept || (state_q != ST_LOCKED) || to_fire) to_cnt_q <= '0;
            else if (stall)                                  to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign lock_timeout = to_pulse_q;
`else
    assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_axis_rr_mux.sv
// Randomized scoreboard bench for axis_rr_mux: a beat-mode/tagged instance and
// a packet-mode/pass-through instance, each checked against a reference model.
module tb_axis_rr_mux;
    localparam int N  = 4;
    localparam int TO = 8;

    typedef struct {
        logic [31:0] data;
        logic [31:0] user;
        logic [31:0] dest;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v   [2][N];
    logic [31:0] dat [2][N];
    logic [31:0] usr [2][N];
    logic [31:0] dst [2][N];
    logic        lst [2][N];
    logic        rdy [2][N];
    logic        ordy [2];
    logic        ov   [2];
    logic [31:0] odat [2];
    logic [31:0] ousr [2];
    logic [31:0] odst [2];
    logic        olst [2];
    logic        lto  [2];

    axi_stream bi [N] ();
    axi_stream bo ();
    axi_stream pi [N] ();
    axi_stream po ();

    for (genvar c = 0; c < N; c++) begin : g_ch
        assign bi[c].valid = v[0][c];
        assign bi[c].data  = dat[0][c];
        assign bi[c].user  = usr[0][c];
        assign bi[c].dest  = dst[0][c];
        assign bi[c].tlast = lst[0][c];
        assign rdy[0][c]   = bi[c].ready;
        assign pi[c].valid = v[1][c];
        assign pi[c].data  = dat[1][c];
        assign pi[c].user  = usr[1][c];
        assign pi[c].dest  = dst[1][c];
        assign pi[c].tlast = lst[1][c];
        assign rdy[1][c]   = pi[c].ready;
    end

    assign bo.ready = ordy[0];
    assign po.ready = ordy[1];
    assign ov[0] = bo.valid;  assign odat[0] = bo.data;  assign ousr[0] = bo.user;
    assign odst[0] = bo.dest; assign olst[0] = bo.tlast;
    assign ov[1] = po.valid;  assign odat[1] = po.data;  assign ousr[1] = po.user;
    assign odst[1] = po.dest; assign olst[1] = po.tlast;

    axis_rr_mux #(.N_CHANNELS(N), .PACKET_MODE(0), .TAG_DEST(1), .TIMEOUT_CYCLES(TO)) dut_beat (
        .clock(clk), .reset(rst), .stream_in(bi), .stream_out(bo)
`ifdef AXIS_MUX_LOCK_TIMEOUT_EN
        , .lock_timeout(lto[0])
`endif
    );

    axis_rr_mux #(.N_CHANNELS(N), .PACKET_MODE(1), .TAG_DEST(0), .TIMEOUT_CYCLES(TO)) dut_pkt (
        .clock(clk), .reset(rst), .stream_in(pi), .stream_out(po)
`ifdef AXIS_MUX_LOCK_TIMEOUT_EN
        , .lock_timeout(lto[1])
`endif
    );

`ifndef AXIS_MUX_LOCK_TIMEOUT_EN
    assign lto[0] = 1'b0;
    assign lto[1] = 1'b0;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sbq0 [$];
    exp_t sbq1 [$];
    int   dlog [$];
    int   m_ptr [2];
    bit   m_lock [2];
    bit   m_ov [2];
    bit   m_to [2];
    int   m_cnt [2];
    int   pkt_left [2][N];
    bit   fired [2][N];
    int   pv = 0, pr = 100, pdrop = 0;
    int   to_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_beat(input int d, input int c);
        dat[d][c] = $urandom;
        usr[d][c] = $urandom;
        dst[d][c] = $urandom;
        if (pkt_left[d][c] == 0) pkt_left[d][c] = $urandom_range(1, 4);
        lst[d][c] = (pkt_left[d][c] == 1);
        pkt_left[d][c]--;
    endtask

    // Reference: rotating priority from the last winner; a lock pins the last winner.
    task automatic step(input int d);
        logic [N-1:0] er, ar;
        bit   can, found;
        int   w;
        exp_t e;
        for (int c = 0; c < N; c++) begin
            ar[c]       = rdy[d][c];
            fired[d][c] = v[d][c] && rdy[d][c];
        end
        if (rst) begin
            chk($sformatf("ready_in_reset_dut%0d", d), 128'(ar), 128'(0));
            if (d == 0) sbq0.delete(); else sbq1.delete();
            m_ptr[d] = N - 1; m_lock[d] = 0; m_ov[d] = 0; m_cnt[d] = 0; m_to[d] = 0;
            return;
        end
        chk($sformatf("out_valid_dut%0d", d), 128'(ov[d]), 128'(m_ov[d]));
`ifdef AXIS_MUX_LOCK_TIMEOUT_EN
        chk($sformatf("lock_timeout_dut%0d", d), 128'(lto[d]), 128'(m_to[d]));
`endif
        m_to[d] = 0;
        can   = !m_ov[d] || ordy[d];
        found = 0;
        w     = 0;
        if (m_lock[d]) begin
            if (v[d][m_ptr[d]]) begin found = 1; w = m_ptr[d]; end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr[d] + k) % N;
                if (!found && v[d][c]) begin found = 1; w = c; end
            end
        end
        er = '0;
        if (can && found) er[w] = 1'b1;
        chk($sformatf("ready_dut%0d", d), 128'(ar), 128'(er));
        if (can && found) begin
            e.data = dat[d][w];
            e.user = usr[d][w];
            e.dest = (d == 0) ? 32'(w) : dst[d][w];
            e.last = lst[d][w];
            if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
            m_ptr[d]  = w;
            m_lock[d] = (d == 1) && !lst[d][w];
            m_cnt[d]  = 0;
            m_ov[d]   = 1;
        end else begin
`ifdef AXIS_MUX_LOCK_TIMEOUT_EN
            if (m_lock[d] && !v[d][m_ptr[d]]) begin
                m_cnt[d]++;
                if (m_cnt[d] == TO) begin
                    m_lock[d] = 0; m_cnt[d] = 0; m_to[d] = 1; to_seen++;
                end
            end
`endif
            if (ordy[d]) m_ov[d] = 0;
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        bit   empty;
        if (rst || !(ov[d] && ordy[d])) return;
        empty = (d == 0) ? (sbq0.size() == 0) : (sbq1.size() == 0);
        if (empty) begin
            checks++;
            failures++;
            $display("FAIL sb_empty_dut%0d: got beat data=%0h expected no beat", d, odat[d]);
            return;
        end
        if (d == 0) e = sbq0.pop_front(); else e = sbq1.pop_front();
        chk($sformatf("beat_dut%0d", d), 128'({odat[d], ousr[d], odst[d], olst[d]}),
            128'({e.data, e.user, e.dest, e.last}));
        if (d == 0) dlog.push_back(int'(odst[d]));
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                if (fired[d][c]) begin
                    new_beat(d, c);
                    v[d][c] = ($urandom_range(0, 99) < pv);
                end else if (v[d][c]) begin
                    if ($urandom_range(0, 99) < pdrop) v[d][c] = 1'b0;
                end else begin
                    v[d][c] = ($urandom_range(0, 99) < pv);
                end
            end
            ordy[d] = ($urandom_range(0, 99) < pr);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        step(0);
        step(1);
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ordy[d] = 1'b1;
            for (int c = 0; c < N; c++) begin
                pkt_left[d][c] = 0;
                fired[d][c]    = 0;
                v[d][c]        = 1'b0;
                new_beat(d, c);
            end
        end
        repeat (3) cycle();
        rst = 1'b0;

        // All channels valid, downstream always ready: strict 0,1,2,3 rotation.
        pv = 100; pr = 100; pdrop = 0;
        for (int d = 0; d < 2; d++) begin
            ordy[d] = 1'b1;
            for (int c = 0; c < N; c++) v[d][c] = 1'b1;
        end
        dlog.delete();
        repeat (12) cycle();
        chk("rotation_count", 128'(dlog.size() >= 6), 128'(1));
        if (dlog.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("rotation_dest%0d", i), 128'(dlog[i]), 128'(i % N));
        end

        // Downstream stalls for 5 cycles with traffic pending.
        pr = 0;
        repeat (5) cycle();
        pr = 100;
        repeat (10) cycle();

        pv = 60; pr = 70; pdrop = 5;
        repeat (1500) cycle();
        pv = 10; pr = 80; pdrop = 20;
        repeat (600) cycle();

        // Reset while the packet instance is locked with a beat on its output.
        pv = 70; pr = 50; pdrop = 0;
        begin
            int guard;
            guard = 0;
            while (!(m_lock[1] && m_ov[1]) && guard < 300) begin
                cycle();
                guard++;
            end
            chk("found_locked_state", 128'(guard < 300), 128'(1));
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int c = 0; c < N; c++) v[1][c] = (c == 0) || (c == 2);
        ordy[1] = 1'b1;
        #2;
        chk("post_reset_out_valid", 128'(ov[1]), 128'(0));
        chk("post_reset_grant_ch0", 128'({rdy[1][0], rdy[1][1], rdy[1][2], rdy[1][3]}), 128'(4'b1000));
        repeat (300) cycle();

        pv = 0; pr = 100; pdrop = 100;
        repeat (8) cycle();
        chk("drain_dut0", 128'(sbq0.size()), 128'(0));
        chk("drain_dut1", 128'(sbq1.size()), 128'(0));
`ifdef AXIS_MUX_LOCK_TIMEOUT_EN
        chk("timeout_exercised", 128'(to_seen > 0), 128'(1));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
